// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: LSL / LSR / ASR / ROR with valid/ready on both sides.
// One binary shift stage is registered per cycle, so latency is $clog2(WIDTH) cycles.
// Optional sticky output (OR of bits shifted out for LSR/ASR) is built only when the
// macro BARREL_SHIFTER_STICKY_EN is defined; otherwise out_sticky is tied to 0.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH),
  localparam int CW  = SHW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    shift_count,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  // Shift d by a fixed amount in the requested mode; ASR replicates the current MSB,
  // which is the sign captured at input because arithmetic shifts never change it.
  function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] m, input int amt);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    case (m)
      MODE_LSL: return d << amt;
      MODE_LSR: return d >> amt;
      MODE_ASR: return $unsigned(sd >>> amt);
      default:  return (d >> amt) | (d << (WIDTH - amt));
    endcase
  endfunction

`ifdef BARREL_SHIFTER_STICKY_EN
  // Bits that fall off the bottom of a right shift; left shift and rotate lose nothing.
  function automatic logic shift_sticky(input logic [WIDTH-1:0] d,
                                        input logic [1:0] m, input int amt);
    if (m == MODE_LSR || m == MODE_ASR) return |(d & ~({WIDTH{1'b1}} << amt));
    else return 1'b0;
  endfunction

  logic [SHW-1:0] sticky_p;
  logic [SHW-1:0] sticky_n;
  logic           front_sticky;
`endif

  logic             en;
  logic [SHW-1:0]   vld_p;
  logic [WIDTH-1:0] data_p [SHW];
  logic [WIDTH-1:0] data_n [SHW];
  logic [SHW-1:0]   cnt_p  [SHW-1];
  logic [SHW-1:0]   cnt_n  [SHW-1];
  logic [1:0]       mode_p [SHW-1];
  logic [1:0]       mode_n [SHW-1];
  logic [WIDTH-1:0] front_data;
  logic [SHW-1:0]   front_cnt;

  // The whole pipe moves together whenever the output slot is free or being drained.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p[SHW-1];
  assign out_data  = data_p[SHW-1];
`ifdef BARREL_SHIFTER_STICKY_EN
  assign out_sticky = sticky_p[SHW-1];
`else
  assign out_sticky = 1'b0;
`endif

  // Over-range override: a count >= WIDTH saturates LSL/LSR/ASR and wraps for ROR.
  always_comb begin
    front_data = in_data;
    front_cnt  = shift_count[SHW-1:0];
`ifdef BARREL_SHIFTER_STICKY_EN
    front_sticky = 1'b0;
`endif
    if (shift_count[CW-1]) begin
      case (mode)
        MODE_LSL: begin
          front_data = '0;
          front_cnt  = '0;
        end
        MODE_LSR: begin
          front_data = '0;
          front_cnt  = '0;
`ifdef BARREL_SHIFTER_STICKY_EN
          front_sticky = |in_data;
`endif
        end
        MODE_ASR: begin
          front_data = {WIDTH{in_data[WIDTH-1]}};
          front_cnt  = '0;
`ifdef BARREL_SHIFTER_STICKY_EN
          front_sticky = |in_data;
`endif
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int AMT = 1 << (SHW - 1 - k);
    logic [WIDTH-1:0] src_d;
    logic [1:0]       src_m;
    logic             shift_en;
`ifdef BARREL_SHIFTER_STICKY_EN
    logic             src_s;
`endif

    if (k == 0) begin : g_first
      assign src_d    = front_data;
      assign src_m    = mode;
      assign shift_en = front_cnt[SHW-1];
      assign cnt_n[0] = front_cnt;
`ifdef BARREL_SHIFTER_STICKY_EN
      assign src_s    = front_sticky;
`endif
    end else begin : g_rest
      assign src_d    = data_p[k-1];
      assign src_m    = mode_p[k-1];
      assign shift_en = cnt_p[k-1][SHW-1-k];
      if (k < SHW - 1) begin : g_fwd
        assign cnt_n[k] = cnt_p[k-1];
      end
`ifdef BARREL_SHIFTER_STICKY_EN
      assign src_s    = sticky_p[k-1];
`endif
    end

    if (k < SHW - 1) begin : g_mode
      assign mode_n[k] = src_m;
    end

    assign data_n[k] = shift_en ? shift_data(src_d, src_m, AMT) : src_d;
`ifdef BARREL_SHIFTER_STICKY_EN
    assign sticky_n[k] = src_s | (shift_en & shift_sticky(src_d, src_m, AMT));
`endif
  end

  // Pipeline registers: all stages advance on en, everything clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      for (int k = 0; k < SHW; k++) data_p[k] <= '0;
      for (int k = 0; k < SHW - 1; k++) begin
        cnt_p[k]  <= '0;
        mode_p[k] <= '0;
      end
`ifdef BARREL_SHIFTER_STICKY_EN
      sticky_p <= '0;
`endif
    end else if (en) begin
      vld_p <= {vld_p[SHW-2:0], in_valid};
      for (int k = 0; k < SHW; k++) data_p[k] <= data_n[k];
      for (int k = 0; k < SHW - 1; k++) begin
        cnt_p[k]  <= cnt_n[k];
        mode_p[k] <= mode_n[k];
      end
`ifdef BARREL_SHIFTER_STICKY_EN
      sticky_p <= sticky_n;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=16, latency 4).
// Sticky expectations follow BARREL_SHIFTER_STICKY_EN.
module tb_pipelined_barrel_shifter;

  localparam int WIDTH = 16;
  localparam int CW    = 5;
`ifdef BARREL_SHIFTER_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CW-1:0]    shift_count;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_count(shift_count), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sticky(out_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        s;
  } exp_t;

  typedef struct {
    logic [15:0] d;
    logic [4:0]  c;
    logic [1:0]  m;
    logic [15:0] ed;
    logic        es;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t rnd_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   n0;
  int   lat;
  int   sz;
  bit   rnd_done;
  logic [15:0] rd;
  logic [4:0]  rc;
  logic [1:0]  rm;

  vec_t dirv [14] = '{
    '{16'h8005, 5'd3,  2'd2, 16'hF000, STK},
    '{16'h1234, 5'd4,  2'd3, 16'h4123, 1'b0},
    '{16'h1234, 5'd20, 2'd3, 16'h4123, 1'b0},
    '{16'hFFFF, 5'd16, 2'd1, 16'h0000, STK},
    '{16'h8000, 5'd31, 2'd2, 16'hFFFF, STK},
    '{16'hABCD, 5'd0,  2'd0, 16'hABCD, 1'b0},
    '{16'h8001, 5'd0,  2'd2, 16'h8001, 1'b0},
    '{16'h00F0, 5'd4,  2'd1, 16'h000F, 1'b0},
    '{16'h00F8, 5'd4,  2'd1, 16'h000F, STK},
    '{16'h8001, 5'd16, 2'd0, 16'h0000, 1'b0},
    '{16'h8001, 5'd1,  2'd3, 16'hC000, 1'b0},
    '{16'hABCD, 5'd16, 2'd3, 16'hABCD, 1'b0},
    '{16'h7FF0, 5'd16, 2'd2, 16'h0000, STK},
    '{16'hF0F0, 5'd8,  2'd0, 16'hF000, 1'b0}
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit-level reference: each result bit is picked from its source position.
  function automatic exp_t model(input logic [15:0] d, input int c, input logic [1:0] m);
    exp_t e;
    int   r;
    e.d = '0;
    e.s = 1'b0;
    r = c % 16;
    for (int i = 0; i < 16; i++) begin
      case (m)
        2'd0: if (i >= c) e.d[i] = d[i-c];
        2'd1: if (i + c < 16) e.d[i] = d[i+c];
        2'd2: e.d[i] = (i + c < 16) ? d[i+c] : d[15];
        default: e.d[i] = d[(i + r) % 16];
      endcase
      if ((m == 2'd1 || m == 2'd2) && i < c) e.s = e.s | d[i];
    end
    e.s = e.s & STK;
    return e;
  endfunction

  // Present one beat, wait (bounded) until it is accepted, record its expectation.
  task automatic drive_beat(input logic [15:0] d, input logic [4:0] c, input logic [1:0] m,
                            input logic [15:0] ed, input logic es);
    exp_t e;
    int   guard;
    in_data     = d;
    shift_count = c;
    mode        = m;
    in_valid    = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      #1;
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    else begin
      e.d = ed;
      e.s = es;
      sb.push_back(e);
    end
    step();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      step();
      guard++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Output side of the scoreboard: compare each accepted result with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", {15'd0, out_sticky, out_data}, 32'hFFFFFFFF);
      else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, mon_e.d);
        chk("out_sticky", out_sticky, mon_e.s);
        n_out++;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; shift_count = '0; mode = '0; out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sticky", out_sticky, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    step();

    // First transfer and its latency
    drive_beat(16'h0001, 5'd5, 2'd0, 16'h0020, 1'b0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 4);
    drain();

    // Directed vectors back-to-back
    for (int i = 0; i < 14; i++)
      drive_beat(dirv[i].d, dirv[i].c, dirv[i].m, dirv[i].ed, dirv[i].es);
    in_valid = 1'b0;
    drain();

    // Backpressure: hold out_ready low for 3 cycles once out_valid rises
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          rd = 16'($urandom); rc = 5'($urandom_range(0, 31)); rm = 2'($urandom_range(0, 3));
          rnd_e = model(rd, rc, rm);
          drive_beat(rd, rc, rm, rnd_e.d, rnd_e.s);
        end
        in_valid = 1'b0;
      end
      begin
        for (int g = 0; g < 50 && !out_valid; g++) step();
        chk("bp_out_valid_rise", out_valid, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold_valid", out_valid, 1);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 6);

    // Reset with beats in flight
    for (int i = 0; i < 8; i++) begin
      rd = 16'($urandom); rc = 5'($urandom_range(0, 31)); rm = 2'($urandom_range(0, 3));
      rnd_e = model(rd, rc, rm);
      drive_beat(rd, rc, rm, rnd_e.d, rnd_e.s);
      if (out_valid) break;
    end
    in_valid = 1'b0;
    sz = sb.size();
    chk("rstmid_queued", sz, 4);
    reset = 1'b1;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    sb.delete();
    step();
    step();
    reset = 1'b0;
    n0 = n_out;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_idle", out_valid, 0);
    end
    chk("post_rst_no_out", n_out - n0, 0);
    drive_beat(16'h8005, 5'd3, 2'd2, 16'hF000, STK);
    in_valid = 1'b0;
    drain();
    chk("post_rst_count", n_out - n0, 1);

    // Random traffic with random backpressure
    n0 = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          rd = 16'($urandom); rc = 5'($urandom_range(0, 31)); rm = 2'($urandom_range(0, 3));
          rnd_e = model(rd, rc, rm);
          drive_beat(rd, rc, rm, rnd_e.d, rnd_e.s);
          in_valid = 1'b0;
          if ($urandom_range(0, 2) == 0) step();
        end
        rnd_done = 1'b1;
      end
      begin
        for (int g = 0; g < 3000 && (!rnd_done || sb.size() != 0); g++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("rand_count", n_out - n0, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
